// File: rtl/permutation_iterative_pkg.sv
`default_nettype none
// ============================================================================
// Module      : permutation_iterative_pkg
// Description : Shared types and tables for the iterative Ascon permutation.
// Revision    : 1.0 - initial release
// ============================================================================
package permutation_iterative_pkg;

    typedef logic [4:0][63:0] type_state;

    typedef logic [0:0] fsm_t;
    localparam fsm_t ST_IDLE = 1'b0;
    localparam fsm_t ST_RUN  = 1'b1;

    localparam int c_NUM_RC = 12;

    localparam logic [7:0] c_RC [c_NUM_RC] = '{
        8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
        8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B
    };

    // Indexed by the column value with S0 as the MSB.
    localparam logic [4:0] c_SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    function automatic logic [7:0] get_rc(input logic [3:0] i_idx);
        logic [7:0] w_rc;
        w_rc = 8'h00;
        if (i_idx < 4'd12) begin
            w_rc = c_RC[i_idx];
        end
        return w_rc;
    endfunction

    function automatic logic [63:0] rotr64(input logic [63:0] i_x, input int i_n);
        return (i_x >> i_n) | (i_x << (64 - i_n));
    endfunction

endpackage
`default_nettype wire

// File: rtl/linear_diffusion.sv
`default_nettype none
// ============================================================================
// Module      : linear_diffusion
// Description : Ascon linear layer, per-word XOR of two right rotations.
// Revision    : 1.0 - initial release
// ============================================================================
module linear_diffusion
    import permutation_iterative_pkg::*;
(
    input  type_state i_state,
    output type_state o_state
);

    assign o_state[0] = i_state[0] ^ rotr64(i_state[0], 19) ^ rotr64(i_state[0], 28);
    assign o_state[1] = i_state[1] ^ rotr64(i_state[1], 61) ^ rotr64(i_state[1], 39);
    assign o_state[2] = i_state[2] ^ rotr64(i_state[2],  1) ^ rotr64(i_state[2],  6);
    assign o_state[3] = i_state[3] ^ rotr64(i_state[3], 10) ^ rotr64(i_state[3], 17);
    assign o_state[4] = i_state[4] ^ rotr64(i_state[4],  7) ^ rotr64(i_state[4], 41);

endmodule
`default_nettype wire

// File: rtl/substitution_layer.sv
`default_nettype none
// ============================================================================
// Module      : substitution_layer
// Description : Ascon 5-bit S-box applied to each of the 64 bit columns.
// Revision    : 1.0 - initial release
// ============================================================================
module substitution_layer
    import permutation_iterative_pkg::*;
(
    input  type_state i_state,
    output type_state o_state
);

    for (genvar j = 0; j < 64; j++) begin : g_col
        logic [4:0] w_col_in;
        logic [4:0] w_col_out;

        assign w_col_in  = {i_state[0][j], i_state[1][j], i_state[2][j],
                            i_state[3][j], i_state[4][j]};
        assign w_col_out = c_SBOX[w_col_in];

        assign o_state[0][j] = w_col_out[4];
        assign o_state[1][j] = w_col_out[3];
        assign o_state[2][j] = w_col_out[2];
        assign o_state[3][j] = w_col_out[1];
        assign o_state[4][j] = w_col_out[0];
    end

endmodule
`default_nettype wire

// File: rtl/permutation_iterative.sv
`default_nettype none
// ============================================================================
// Module      : permutation_iterative
// Description : Iterative Ascon permutation, one round per clock (p^a / p^b).
// Revision    : 1.0 - initial release
// ============================================================================
module permutation_iterative
    import permutation_iterative_pkg::*;
#(
    parameter int ROUNDS_A = 12,
    parameter int ROUNDS_B = 6
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       rounds_sel_i,
    input  type_state  state_i,
    output type_state  state_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [3:0] round_o
);

    localparam logic [3:0] c_START_A = 4'(c_NUM_RC - ROUNDS_A);
    localparam logic [3:0] c_START_B = 4'(c_NUM_RC - ROUNDS_B);
    localparam logic [3:0] c_LAST    = 4'(c_NUM_RC - 1);

    type_state  r_state;
    logic [3:0] r_round;
    fsm_t       r_fsm;
    logic       r_done;

    type_state  w_ca;
    type_state  w_sl;
    type_state  w_ld;

    // Constant addition touches only the low byte of S2.
    always_comb begin
        w_ca       = r_state;
        w_ca[2][7:0] = r_state[2][7:0] ^ get_rc(r_round);
    end

    substitution_layer u_substitution_layer (
        .i_state (w_ca),
        .o_state (w_sl)
    );

    linear_diffusion u_linear_diffusion (
        .i_state (w_sl),
        .o_state (w_ld)
    );

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= '0;
            r_round <= 4'd0;
            r_fsm   <= ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_fsm)
                ST_IDLE: begin
                    if (start_i) begin
                        r_state <= state_i;
                        r_round <= rounds_sel_i ? c_START_B : c_START_A;
                        r_fsm   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_state <= w_ld;
                    // Counter stays at the last index so round_o reads 11 when idle.
                    if (r_round == c_LAST) begin
                        r_fsm  <= ST_IDLE;
                        r_done <= 1'b1;
                    end else begin
                        r_round <= r_round + 4'd1;
                    end
                end
                default: begin
                    r_fsm <= ST_IDLE;
                end
            endcase
        end
    end

    assign state_o = r_state;
    assign busy_o  = (r_fsm == ST_RUN);
    assign done_o  = r_done;
    assign round_o = r_round;

endmodule
`default_nettype wire

// File: tb/tb_permutation_iterative.sv
`default_nettype none
// ============================================================================
// Module      : tb_permutation_iterative
// Description : Self-checking bench with a bitsliced Ascon reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_permutation_iterative;
    import permutation_iterative_pkg::*;

    localparam int NA = 12;
    localparam int NB = 6;

    logic       clock_i = 1'b0;
    logic       reset_i = 1'b0;
    logic       start_i = 1'b0;
    logic       rounds_sel_i = 1'b0;
    type_state  state_i = '0;
    type_state  state_o;
    logic       busy_o;
    logic       done_o;
    logic [3:0] round_o;

    int checks = 0;
    int errors = 0;

    permutation_iterative #(.ROUNDS_A(NA), .ROUNDS_B(NB)) dut (
        .clock_i      (clock_i),
        .reset_i      (reset_i),
        .start_i      (start_i),
        .rounds_sel_i (rounds_sel_i),
        .state_i      (state_i),
        .state_o      (state_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .round_o      (round_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // Reference round: round constant built as ((15-r)<<4)|r, bitsliced S-box.
    function automatic type_state model_round(input type_state s, input int r);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        type_state o;
        x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
        x2 = x2 ^ {56'd0, 4'(15 - r), 4'(r)};
        x0 ^= x4; x4 ^= x3; x2 ^= x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
        x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
        o[0] = x0 ^ rr(x0, 19) ^ rr(x0, 28);
        o[1] = x1 ^ rr(x1, 61) ^ rr(x1, 39);
        o[2] = x2 ^ rr(x2, 1)  ^ rr(x2, 6);
        o[3] = x3 ^ rr(x3, 10) ^ rr(x3, 17);
        o[4] = x4 ^ rr(x4, 7)  ^ rr(x4, 41);
        return o;
    endfunction

    function automatic type_state model_perm(input type_state s, input int n);
        type_state t;
        t = s;
        for (int r = 12 - n; r < 12; r++) t = model_round(t, r);
        return t;
    endfunction

    function automatic type_state rnd_state();
        type_state s;
        for (int w = 0; w < 5; w++) s[w] = {$urandom, $urandom};
        return s;
    endfunction

    // One permutation; optionally pulses a disturbing start at round step dist_k.
    task automatic run_perm(input string tag, input logic sel, input type_state st, input int dist_k);
        int        n;
        type_state exp;
        n   = sel ? NB : NA;
        exp = model_perm(st, n);
        @(negedge clock_i);
        start_i = 1'b1; rounds_sel_i = sel; state_i = st;
        @(negedge clock_i);
        start_i = 1'b0; rounds_sel_i = ~sel; state_i = rnd_state();
        for (int k = 0; k < n; k++) begin
            chk({tag, " round_o"}, 320'(round_o), 320'(12 - n + k));
            chk({tag, " busy_o"},  320'(busy_o),  320'(1));
            chk({tag, " done_o early"}, 320'(done_o), 320'(0));
            if (k == dist_k) begin
                start_i = 1'b1; state_i = rnd_state(); rounds_sel_i = ~sel;
            end
            @(negedge clock_i);
            start_i = 1'b0;
        end
        chk({tag, " done_o"}, 320'(done_o), 320'(1));
        chk({tag, " busy_o idle"}, 320'(busy_o), 320'(0));
        chk({tag, " state_o"}, state_o, exp);
        chk({tag, " round_o hold"}, 320'(round_o), 320'(11));
        @(negedge clock_i);
        state_i = rnd_state();
        chk({tag, " done_o single"}, 320'(done_o), 320'(0));
        @(negedge clock_i);
        chk({tag, " state_o stable"}, state_o, exp);
    endtask

    initial begin
        type_state st;
        type_state a_st;
        int        pulses;
        int        p1;
        int        p2;

        // Asynchronous reset between edges.
        #23 reset_i = 1'b1;
        #1;
        chk("reset state_o", state_o, '0);
        chk("reset busy_o",  320'(busy_o),  320'(0));
        chk("reset done_o",  320'(done_o),  320'(0));
        chk("reset round_o", 320'(round_o), 320'(0));
        @(negedge clock_i);
        reset_i = 1'b0;

        run_perm("pa zero", 1'b0, '0, -1);

        st = '0;
        st[0] = 64'h80400c0600000000;
        st[1] = {$urandom, $urandom}; st[2] = {$urandom, $urandom};
        st[3] = {$urandom, $urandom}; st[4] = {$urandom, $urandom};
        run_perm("pb key", 1'b1, st, -1);

        for (int i = 0; i < 3; i++) begin
            run_perm("pa rand", 1'b0, rnd_state(), -1);
            run_perm("pb rand", 1'b1, rnd_state(), -1);
        end

        run_perm("pa ignore start", 1'b0, rnd_state(), 4);
        run_perm("pb ignore start", 1'b1, rnd_state(), 2);

        // Single round of p^b on zero, then abort by reset.
        @(negedge clock_i);
        start_i = 1'b1; rounds_sel_i = 1'b1; state_i = '0;
        @(negedge clock_i);
        start_i = 1'b0;
        chk("single round_o", 320'(round_o), 320'(6));
        @(negedge clock_i);
        chk("single state_o", state_o, model_round('0, 6));
        #2 reset_i = 1'b1;
        #1;
        chk("abort1 state_o", state_o, '0);
        chk("abort1 busy_o", 320'(busy_o), 320'(0));
        @(negedge clock_i);
        reset_i = 1'b0;

        // Reset at round 5 of p^a: no done pulse, then a clean rerun.
        @(negedge clock_i);
        start_i = 1'b1; rounds_sel_i = 1'b0; state_i = rnd_state();
        @(negedge clock_i);
        start_i = 1'b0;
        repeat (5) @(negedge clock_i);
        chk("abort2 at round", 320'(round_o), 320'(5));
        #2 reset_i = 1'b1;
        #1;
        chk("abort2 state_o", state_o, '0);
        chk("abort2 busy_o",  320'(busy_o),  320'(0));
        chk("abort2 done_o",  320'(done_o),  320'(0));
        chk("abort2 round_o", 320'(round_o), 320'(0));
        @(negedge clock_i);
        reset_i = 1'b0;
        pulses = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clock_i);
            if (done_o === 1'b1) pulses++;
        end
        chk("abort2 no done", 320'(pulses), 320'(0));
        run_perm("pa after abort", 1'b0, rnd_state(), -1);

        // Start held high across done: rerun accepted in the done cycle.
        a_st = rnd_state();
        p1 = -1; p2 = -1;
        @(negedge clock_i);
        start_i = 1'b1; rounds_sel_i = 1'b0; state_i = a_st;
        for (int e = 1; e <= 40 && p2 < 0; e++) begin
            @(negedge clock_i);
            if (done_o === 1'b1) begin
                if (p1 < 0) p1 = e;
                else begin
                    p2 = e;
                    start_i = 1'b0;
                end
            end
        end
        start_i = 1'b0;
        chk("b2b first pulse", 320'(p1), 320'(13));
        chk("b2b pulse spacing", 320'(p2 - p1), 320'(13));
        chk("b2b state_o", state_o, model_perm(a_st, NA));
        @(negedge clock_i);
        chk("b2b idle busy_o", 320'(busy_o), 320'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
